// File: rtl/dg0045_pkg.sv
// rtl/dg0045_pkg.sv - shared constants and enums for the DG0045 RAM access controller
//
// Holds the RAM geometry (ADDR_W, DATA_W, RAM_DEPTH), the display map
// (DISP_BASE, NUM_DIGITS), the default scan period, the bus-owner enum
// and the CPU access FSM state enum.
package dg0045_pkg;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 4;
  localparam int RAM_DEPTH  = 1 << ADDR_W;

  localparam int DISP_BASE  = 24;
  localparam int NUM_DIGITS = 8;
  localparam int SCAN_DIV   = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_SCAN
  } bus_owner_e;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } cpu_state_e;

endpackage

// File: rtl/dg0045_scan_timer.sv
// rtl/dg0045_scan_timer.sv - display scan divider, digit index and one-hot decode
//
// Ports:
//   RAM_clk       in   system clock
//   RAM_rst       in   asynchronous active-high reset
//   scan_slot     out  high in the cycle that owns the RAM for a digit fetch
//   digit_idx     out  index of the digit fetched in the current scan slot
//   digit_onehot  out  one-hot decode of digit_idx
module dg0045_scan_timer #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 4,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic                  RAM_clk,
  input  logic                  RAM_rst,
  output logic                  scan_slot,
  output logic [IDX_W-1:0]      digit_idx,
  output logic [NUM_DIGITS-1:0] digit_onehot
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] div_cnt;

  // The divider free-runs; the scan slot is its terminal count, so the
  // display fetch can never be pushed back by CPU traffic.
  assign scan_slot = (div_cnt == CNT_LAST);

  always_ff @(posedge RAM_clk or posedge RAM_rst) begin
    if (RAM_rst) begin
      div_cnt <= '0;
    end else if (scan_slot) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge RAM_clk or posedge RAM_rst) begin
    if (RAM_rst) begin
      digit_idx <= '0;
    end else if (scan_slot) begin
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end
  end

  assign digit_onehot = NUM_DIGITS'(1) << digit_idx;

endmodule

// File: rtl/dg0045_ram_access_ctrl.sv
// rtl/dg0045_ram_access_ctrl.sv - RAM bus master arbitrating CPU nibble access and display scan
//
// Ports:
//   RAM_clk      in   system clock, all state on rising edge
//   RAM_rst      in   asynchronous active-high reset
//   cpu_req      in   access request, held until cpu_ack
//   cpu_we       in   1 = write, 0 = read
//   cpu_addr     in   nibble address
//   cpu_wdata    in   write nibble
//   cpu_ack      out  one-cycle completion pulse
//   cpu_rdata    out  pre-access contents of the addressed nibble, valid with cpu_ack
//   ram_addr     out  RAM address bus
//   ram_din      out  RAM data-in bus (RAM writes it every cycle)
//   ram_dout     in   RAM combinational read data for ram_addr
//   digit_sel    out  one-hot digit enable
//   digit_val    out  nibble for the selected digit
//   digit_valid  out  one-cycle pulse when digit_sel/digit_val update
module dg0045_ram_access_ctrl #(
  parameter int ADDR_W     = dg0045_pkg::ADDR_W,
  parameter int DATA_W     = dg0045_pkg::DATA_W,
  parameter int NUM_DIGITS = dg0045_pkg::NUM_DIGITS,
  parameter int DISP_BASE  = dg0045_pkg::DISP_BASE,
  parameter int SCAN_DIV   = dg0045_pkg::SCAN_DIV
) (
  input  logic                  RAM_clk,
  input  logic                  RAM_rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [DATA_W-1:0]     digit_val,
  output logic                  digit_valid
);

  import dg0045_pkg::*;

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                  scan_slot;
  logic [IDX_W-1:0]      digit_idx;
  logic [NUM_DIGITS-1:0] digit_onehot;

  bus_owner_e owner;
  cpu_state_e state_q;
  cpu_state_e state_d;

  dg0045_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .IDX_W      (IDX_W)
  ) u_scan_timer (
    .RAM_clk      (RAM_clk),
    .RAM_rst      (RAM_rst),
    .scan_slot    (scan_slot),
    .digit_idx    (digit_idx),
    .digit_onehot (digit_onehot)
  );

  // Scan has absolute priority. Ownership is also forced to NONE while reset
  // is asserted so a held cpu_req cannot write the RAM during reset.
  always_comb begin
    owner = OWN_NONE;
    if (RAM_rst) begin
      owner = OWN_NONE;
    end else if (scan_slot) begin
      owner = OWN_SCAN;
    end else if ((state_q == ST_IDLE) && cpu_req) begin
      owner = OWN_CPU;
    end
  end

  // The RAM writes din every cycle, so every path except a CPU write loops
  // the read data back to keep the addressed word unchanged.
  always_comb begin
    ram_addr = '0;
    ram_din  = ram_dout;
    case (owner)
      OWN_SCAN: begin
        ram_addr = ADDR_W'(DISP_BASE) + ADDR_W'(digit_idx);
        ram_din  = ram_dout;
      end
      OWN_CPU: begin
        ram_addr = cpu_addr;
        ram_din  = cpu_we ? cpu_wdata : ram_dout;
      end
      default: begin
        ram_addr = '0;
        ram_din  = ram_dout;
      end
    endcase
  end

  always_ff @(posedge RAM_clk or posedge RAM_rst) begin
    if (RAM_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ACK is a mandatory one-cycle gap: requests seen there are ignored, which
  // caps the CPU at one access every two cycles.
  always_comb begin
    state_d = state_q;
    cpu_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (owner == OWN_CPU) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        cpu_ack = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Captured before the RAM edge, so a write returns the old contents.
  always_ff @(posedge RAM_clk or posedge RAM_rst) begin
    if (RAM_rst) begin
      cpu_rdata <= '0;
    end else if (owner == OWN_CPU) begin
      cpu_rdata <= ram_dout;
    end
  end

  always_ff @(posedge RAM_clk or posedge RAM_rst) begin
    if (RAM_rst) begin
      digit_sel   <= '0;
      digit_val   <= '0;
      digit_valid <= 1'b0;
    end else begin
      digit_valid <= (owner == OWN_SCAN);
      if (owner == OWN_SCAN) begin
        digit_sel <= digit_onehot;
        digit_val <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_dg0045_ram_access_ctrl.sv
// tb/tb_dg0045_ram_access_ctrl.sv - self-checking bench for dg0045_ram_access_ctrl
module tb_dg0045_ram_access_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 4;
  localparam int ND    = 8;
  localparam int BASE  = 24;
  localparam int DIV   = 4;
  localparam int DEPTH = 32;

  logic          RAM_clk = 1'b0;
  logic          RAM_rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [ND-1:0] digit_sel;
  logic [DW-1:0] digit_val;
  logic          digit_valid;

  int total = 0;
  int bad = 0;

  logic preload_req = 1'b1;
  logic run_checks = 1'b0;

  dg0045_ram_access_ctrl dut (
    .RAM_clk     (RAM_clk),
    .RAM_rst     (RAM_rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout),
    .digit_sel   (digit_sel),
    .digit_val   (digit_val),
    .digit_valid (digit_valid)
  );

  always #5 RAM_clk = ~RAM_clk;

  // RAM: no write enable, writes din every edge, combinational read.
  logic [DW-1:0] mem [DEPTH];

  always @(posedge RAM_clk) begin
    if (preload_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i);
    end else begin
      mem[ram_addr] <= ram_din;
    end
  end

  assign ram_dout = mem[ram_addr];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle-count view of the behaviour. Every edge since
  // reset is numbered; every DIV-th edge is a digit fetch of the next digit
  // in sequence; the CPU gets an access on any other edge if it is asking
  // and did not just complete one. The RAM is modelled as a shadow array that
  // only CPU writes may change.
  int            cyc_m;
  int            scans_m;
  logic          ack_m;
  logic [DW-1:0] rdata_m;
  logic          dv_m;
  logic [ND-1:0] dsel_m;
  logic [DW-1:0] dval_m;
  logic [DW-1:0] shadow [DEPTH];

  always @(posedge RAM_clk or posedge RAM_rst) begin
    if (RAM_rst) begin
      cyc_m   = 0;
      scans_m = 0;
      ack_m   = 1'b0;
      rdata_m = '0;
      dv_m    = 1'b0;
      dsel_m  = '0;
      dval_m  = '0;
      if (preload_req) begin
        for (int i = 0; i < DEPTH; i++) shadow[i] = DW'(i);
      end
    end else begin
      logic slot;
      logic go;
      int   d;
      slot = ((cyc_m % DIV) == DIV - 1);
      go   = !slot && !ack_m && cpu_req;
      dv_m = slot;
      if (slot) begin
        d       = scans_m % ND;
        dsel_m  = ND'(1) << d;
        dval_m  = shadow[BASE + d];
        scans_m = scans_m + 1;
      end
      if (go) begin
        rdata_m = shadow[cpu_addr];
        if (cpu_we) shadow[cpu_addr] = cpu_wdata;
      end
      ack_m = go;
      cyc_m = cyc_m + 1;
    end
  end

  always @(negedge RAM_clk) begin
    if (run_checks) begin
      logic [127:0] mem_v;
      logic [127:0] sh_v;
      for (int i = 0; i < DEPTH; i++) begin
        mem_v[i*4 +: 4] = mem[i];
        sh_v[i*4 +: 4]  = shadow[i];
      end
      chk("cyc_cpu_ack", 128'(cpu_ack), 128'(ack_m));
      chk("cyc_cpu_rdata", 128'(cpu_rdata), 128'(rdata_m));
      chk("cyc_digit_valid", 128'(digit_valid), 128'(dv_m));
      chk("cyc_digit_sel", 128'(digit_sel), 128'(dsel_m));
      chk("cyc_digit_val", 128'(digit_val), 128'(dval_m));
      chk("cyc_ram_contents", mem_v, sh_v);
    end
  end

  task automatic tick();
    @(posedge RAM_clk);
    #1;
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while ((cyc_m % DIV) != ph && n < 2 * DIV) begin
      tick();
      n++;
    end
    chk("wait_phase_timeout", 128'((cyc_m % DIV) == ph), 128'(1));
  endtask

  initial begin
    int n_pulses;
    int k;
    int acks;

    tick();
    preload_req = 1'b0;
    run_checks  = 1'b1;
    tick();
    chk("rst_cpu_ack", 128'(cpu_ack), 128'(0));
    chk("rst_digit_sel", 128'(digit_sel), 128'(0));
    chk("rst_ram_addr", 128'(ram_addr), 128'(0));
    RAM_rst = 1'b0;

    // Idle scan: pulses every 4 cycles, digits 0..7 twice over.
    n_pulses = 0;
    for (int t = 1; t <= 64; t++) begin
      tick();
      if (digit_valid) begin
        chk("idle_pulse_spacing", 128'(t % 4), 128'(0));
        chk("idle_digit_sel", 128'(digit_sel), 128'(ND'(1) << (n_pulses % 8)));
        chk("idle_digit_val", 128'(digit_val), 128'(8 + (n_pulses % 8)));
        n_pulses++;
      end
    end
    chk("idle_pulse_count", 128'(n_pulses), 128'(16));

    // Write 0x9 to addr 26 outside the scan slot.
    wait_phase(0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd26; cpu_wdata = 4'h9;
    tick();
    chk("wr_ack_latency", 128'(cpu_ack), 128'(1));
    chk("wr_old_rdata", 128'(cpu_rdata), 128'(4'hA));
    cpu_req = 1'b0; cpu_we = 1'b0;
    k = 0;
    while (!(digit_valid && digit_sel == 8'h04) && k < 40) begin
      tick();
      k++;
    end
    chk("wr_digit2_found", 128'(k < 40), 128'(1));
    chk("wr_digit2_val", 128'(digit_val), 128'(4'h9));

    // Read requested exactly in the scan cycle: deferred by one.
    wait_phase(3);
    cpu_req = 1'b1; cpu_addr = 5'd24;
    tick();
    chk("defer_no_ack", 128'(cpu_ack), 128'(0));
    chk("defer_scan_ok", 128'(digit_valid), 128'(1));
    tick();
    chk("defer_ack", 128'(cpu_ack), 128'(1));
    chk("defer_rdata", 128'(cpu_rdata), 128'(4'h8));
    cpu_req = 1'b0;

    // Back-to-back reads of addr 5 with req held high.
    wait_phase(0);
    cpu_req = 1'b1; cpu_addr = 5'd5;
    acks = 0;
    for (int t = 0; t < 24; t++) begin
      tick();
      if (cpu_ack) begin
        acks++;
        chk("stream_rdata", 128'(cpu_rdata), 128'(4'h5));
      end
    end
    cpu_req = 1'b0;
    chk("stream_ack_count", 128'(acks), 128'(12));
    chk("stream_mem5", 128'(mem[5]), 128'(4'h5));

    // Reset during the ACK cycle.
    wait_phase(0);
    cpu_req = 1'b1; cpu_addr = 5'd27;
    tick();
    chk("rstack_pre_ack", 128'(cpu_ack), 128'(1));
    RAM_rst = 1'b1;
    #1;
    chk("rstack_ack_drop", 128'(cpu_ack), 128'(0));
    chk("rstack_rdata", 128'(cpu_rdata), 128'(0));
    chk("rstack_digit_sel", 128'(digit_sel), 128'(0));
    chk("rstack_digit_val", 128'(digit_val), 128'(0));
    cpu_req = 1'b0;
    tick();
    tick();
    RAM_rst = 1'b0;
    k = 0;
    while (!digit_valid && k < 10) begin
      tick();
      k++;
    end
    chk("rstack_first_valid", 128'(k), 128'(4));
    chk("rstack_first_sel", 128'(digit_sel), 128'(8'h01));
    chk("rstack_first_val", 128'(digit_val), 128'(4'h8));
    for (int t = 0; t < 8; t++) tick();
    chk("rstack_mem26", 128'(mem[26]), 128'(4'h9));
    chk("rstack_mem27", 128'(mem[27]), 128'(4'hB));

    run_checks = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dg0045_ram_access_ctrl.md
Name: dg0045_ram_access_ctrl

Overview:
- Sole master of the DG0045 128-bit nibble RAM's address and data-in buses, sitting directly upstream of the RAM.
- The RAM writes `din` into `mem[addr]` on every `RAM_clk` edge and has no write enable. This block therefore drives `din` with the addressed nibble on non-write cycles, so contents are preserved.
- It arbitrates between CPU nibble read/write requests and a periodic display-scan fetch. It presents one scanned display digit at a time to the LCD driver.

Parameters:
- ADDR_W, 5, RAM address width (32 nibbles).
- DATA_W, 4, nibble width.
- NUM_DIGITS, 8, display digits scanned; range 2..16.
- DISP_BASE, 24, RAM address of digit 0. Constraint: DISP_BASE+NUM_DIGITS <= 2**ADDR_W.
- SCAN_DIV, 4, clock cycles per digit fetch; minimum 2.

Ports:
- RAM_clk  in  1  system clock; all state on rising edge.
- RAM_rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access request; held until cpu_ack.
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
- cpu_addr  in  ADDR_W  nibble address.
- cpu_wdata  in  DATA_W  write nibble.
- cpu_ack  out  1  one-cycle pulse, access complete.
- cpu_rdata  out  DATA_W  registered read nibble; valid while cpu_ack=1.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_din  out  DATA_W  to RAM din.
- ram_dout  in  DATA_W  from RAM dout (combinational read of ram_addr).
- digit_sel  out  NUM_DIGITS  one-hot digit enable.
- digit_val  out  DATA_W  nibble for selected digit.
- digit_valid  out  1  one-cycle pulse when digit_sel/digit_val update.

Behaviour:
- Reset (async, while RAM_rst=1):
  - cpu_ack=0, cpu_rdata=0, digit_sel=0, digit_val=0, digit_valid=0.
  - div_cnt=0, digit_idx=0, FSM=IDLE.
  - ram_addr=0 and ram_din=ram_dout, so RAM contents are preserved through reset.
- Bus owner, decided combinationally each cycle:
  - SCAN if div_cnt==SCAN_DIV-1.
  - Else CPU if FSM==IDLE and cpu_req=1.
  - Else NONE.
- Bus drive by owner:
  - SCAN: ram_addr=DISP_BASE+digit_idx, ram_din=ram_dout.
  - CPU: ram_addr=cpu_addr; ram_din=cpu_wdata if cpu_we, else ram_dout.
  - NONE: ram_addr=0, ram_din=ram_dout.
- div_cnt: increments every cycle and wraps SCAN_DIV-1 -> 0. The scan slot is never delayed.
- FSM:
  - IDLE -> ACK on a CPU-owned cycle. At that edge, cpu_rdata<=ram_dout, i.e. the pre-write value; for a write it returns the old contents.
  - ACK: cpu_ack=1 for exactly one cycle; the bus is not used by the CPU. Then ACK -> IDLE unconditionally.
  - cpu_req seen during ACK is ignored. A still-asserted req in the following IDLE cycle is a new access.
  - Maximum CPU throughput: one access per 2 cycles.
- CPU request colliding with the scan slot: CPU access waits exactly one cycle. ack latency from req becomes 2 cycles instead of 1.
- Scan cycle, at the edge:
  - digit_val<=ram_dout.
  - digit_sel<=onehot(digit_idx).
  - digit_valid<=1 for one cycle (0 otherwise).
  - digit_idx<=(digit_idx==NUM_DIGITS-1)?0:digit_idx+1.
- digit_sel/digit_val hold between fetches.
- CPU write to a display address is visible at that digit's next fetch.
- Address arithmetic: DISP_BASE+digit_idx is computed at ADDR_W bits and does not overflow under the parameter constraint.
- Reset mid-access: ack is dropped and the pending access is abandoned. The requester re-issues after reset.

Decomposition:
- Shared package dg0045_pkg holds:
  - ADDR_W, DATA_W, the RAM depth constant.
  - Display map constants DISP_BASE and NUM_DIGITS.
  - Bus-owner enum {OWN_NONE, OWN_CPU, OWN_SCAN}.
  - FSM enum {ST_IDLE, ST_ACK}.
- One natural sub-module: dg0045_scan_timer, containing div_cnt, digit_idx, the scan-slot flag and the one-hot decode.
- Arbitration, the bus mux and the CPU FSM stay in the top.

Test Plan:
- Reset, then idle 64 cycles, with the RAM preloaded with addr[3:0] in every word:
  - no RAM word changes;
  - digit_valid pulses every 4 cycles;
  - digit_sel walks 0x01..0x80 and wraps;
  - digit_val=8..15 (addresses 24..31).
- CPU write addr 26 data 0x9 in a non-scan cycle:
  - cpu_ack 1 cycle later;
  - cpu_rdata=0xA (old);
  - the next fetch of digit 2 gives digit_val=0x9.
- CPU read asserted exactly in the scan cycle (div_cnt=3): access deferred one cycle, cpu_ack 2 cycles after req, scan fetch unaffected.
- cpu_req held high continuously with reads of addr 5:
  - ack every 2nd cycle, never during a scan cycle;
  - cpu_rdata=0x5;
  - RAM unchanged.
- Assert RAM_rst during the ACK cycle:
  - cpu_ack drops immediately;
  - all outputs return to 0;
  - RAM contents are intact after release;
  - scanning restarts at digit 0, with the first digit_valid 4 cycles after release.
